atom_rv_wb_core: RTL and testbench
==================================

// Module: atom_rv_wb_core
// PURPOSE
//   Multicycle RV32I processor core with separate Wishbone instruction and data master ports.
//   It fetches from a word-wide instruction ROM on ibus and loads/stores to a byte-selectable RAM on dbus.
//   It is the sole bus master in the barebone SoC, next to imem and dmem.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset.
// PORTS
//   wb_clk_i       in   1   single core clock; all state changes on rising edge
//   wb_rst_i       in   1   reset, asynchronous, active-low (0 = reset)
//   wb_ibus_adr_o  out  32  fetch address (PC, bits[1:0]=0)
//   wb_ibus_dat_i  in   32  fetched instruction word
//   wb_ibus_stb_o  out  1   fetch request strobe
//   wb_ibus_ack_i  in   1   fetch data valid
//   wb_dbus_adr_o  out  32  data address, word aligned (bits[1:0]=0)
//   wb_dbus_dat_o  out  32  store data, lane-replicated
//   wb_dbus_dat_i  in   32  load data (full word)
//   wb_dbus_we_o   out  1   1 = store, 0 = load
//   wb_dbus_sel_o  out  4   byte lane enables
//   wb_dbus_stb_o  out  1   data request strobe
//   wb_dbus_ack_i  in   1   data transfer complete
//   wb_dbus_cyc_o  out  1   data cycle active; equals wb_dbus_stb_o
// BEHAVIOUR
// - Reset (async, while wb_rst_i=0):
//   - PC=RESET_PC; state=FETCH.
//   - All stb/cyc/we=0, sel=0, adr/dat_o=0.
//   - x1..x31 are not cleared.
// - Register file: x0 always reads 0; writes to x0 are discarded.
// - FSM state FETCH: ibus_stb=1, ibus_adr=PC; held (adr stable) until ibus_ack=1.
//   - On ack: latch IR, go to EXEC.
// - FSM state EXEC (1 cycle): decode and execute the latched instruction.
//   - ALU, LUI, AUIPC, JAL, JALR, branches: write rd, update PC, go to FETCH.
//   - Load/store: register address and data, go to MEM.
// - FSM state MEM: dbus_stb=cyc=1 held until dbus_ack=1.
//   - On ack: loads write rd from the extracted lane; go to FETCH; stb/cyc drop the next cycle.
// - Handshake: no request is withdrawn before its ack. Ack with stb low is ignored.
// - ISA: all RV32I base ops.
//   - Arithmetic is 32-bit wraparound.
//   - Shifts use rs2[4:0] or shamt; SRA/SRAI sign-fill.
//   - SLT signed, SLTU unsigned compare.
//   - Branch/JAL targets are PC-relative from the instruction PC.
//   - JALR target = (rs1+imm)&~1; rd=PC+4.
//   - FENCE, ECALL, EBREAK, CSR ops and illegal encodings: NOP (PC+4).
// - Address: ea=rs1+imm; dbus_adr={ea[31:2],2'b00}.
// - SB:
//   - sel = 1<<ea[1:0]
//   - dat_o = {4{rs2[7:0]}}
// - SH:
//   - sel = ea[1] ? 4'b1100 : 4'b0011
//   - dat_o = {2{rs2[15:0]}}
// - SW: sel=4'b1111. Loads drive sel the same way as stores of that size.
// - LB/LBU/LH/LHU: extract the lane selected by ea[1:0] (halfword by ea[1]); sign- or zero-extend.
// - Misaligned accesses: ea[0] is ignored for halfwords and ea[1:0] for words; no trap.
// - Timing with 1-wait memories:
//   - ALU op = 3 cycles (fetch request, ack, exec).
//   - Load/store = 5 cycles.
// - Reset mid-transaction aborts it; stb drops immediately (async).
// TESTING
// - Reset: hold wb_rst_i=0 4 cycles then 1.
//   - Expect stb=0 during reset.
//   - Expect first ibus_adr=0x0, stb=1 the cycle after release.
// - Fetch stall: delay ibus_ack 3 cycles -> adr/stb stay constant; PC advances only after ack.
// - ALU: addi x1,x0,-1; srai x2,x1,4; sltu x3,x0,x1 -> x1=0xFFFFFFFF, x2=0xFFFFFFFF, x3=1.
// - Store: x5=0x000000AB; sb x5,0x103(x0) -> dbus_adr=0x100, sel=4'b1000, dat_o=0xABABABAB, we=1.
// - Load: RAM[0x100]=0x80FF7F01.
//   - lb @0x101 -> 0x0000007F.
//   - lh @0x102 -> 0xFFFF80FF.
//   - lbu @0x103 -> 0x80.
// - Control flow: beq x0,x0,+8 at 0x10 -> next fetch 0x18; jal x1,-8 -> x1=PC+4; x0 remains 0.

Source files
------------

// File: rtl/atom_rv_wb_core.sv
// atom_rv_wb_core: multicycle RV32I core (FETCH -> EXEC -> [MEM] -> FETCH)
// with separate Wishbone instruction and data master ports.
module atom_rv_wb_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    output logic [31:0] wb_ibus_adr_o,
    input  logic [31:0] wb_ibus_dat_i,
    output logic        wb_ibus_stb_o,
    input  logic        wb_ibus_ack_i,
    output logic [31:0] wb_dbus_adr_o,
    output logic [31:0] wb_dbus_dat_o,
    input  logic [31:0] wb_dbus_dat_i,
    output logic        wb_dbus_we_o,
    output logic [3:0]  wb_dbus_sel_o,
    output logic        wb_dbus_stb_o,
    input  logic        wb_dbus_ack_i,
    output logic        wb_dbus_cyc_o
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] dadr_q, dadr_d;
    logic [31:0] ddat_q, ddat_d;
    logic [3:0]  dsel_q, dsel_d;
    logic        dwe_q, dwe_d;
    logic        dstb_q, dstb_d;
    logic [1:0]  ea_lo_q, ea_lo_d;

    logic [31:0] rf [0:31];
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] pc_plus4;

    logic        opimm_ok;
    logic        op_ok;
    logic        do_lui;
    logic        do_auipc;
    logic        do_jal;
    logic        do_jalr;
    logic        do_br;
    logic        do_ld;
    logic        do_st;
    logic        do_alu;

    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_y;
    logic        br_take;
    logic [31:0] ea;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdat;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_v;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];

    assign rs1_v = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
    assign rs2_v = (rs2 == 5'd0) ? 32'h0 : rf[rs2];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                    ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'h000};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                    ir_q[20], ir_q[30:21], 1'b0};

    assign pc_plus4 = pc_q + 32'd4;

    // Encoding legality; anything that fails decodes as a NOP
    always_comb begin
        opimm_ok = 1'b1;
        if (f3 == 3'b001) begin
            opimm_ok = (f7 == 7'h00);
        end else if (f3 == 3'b101) begin
            opimm_ok = (f7 == 7'h00) || (f7 == 7'h20);
        end
        op_ok = (f7 == 7'h00) ||
                ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
    end

    assign do_lui   = (opcode == OP_LUI);
    assign do_auipc = (opcode == OP_AUIPC);
    assign do_jal   = (opcode == OP_JAL);
    assign do_jalr  = (opcode == OP_JALR) && (f3 == 3'b000);
    assign do_br    = (opcode == OP_BRANCH) && (f3[2:1] != 2'b01);
    assign do_ld    = (opcode == OP_LOAD) &&
                      (f3 != 3'b011) && (f3[2:1] != 2'b11);
    assign do_st    = (opcode == OP_STORE) && (f3[2:1] != 2'b11) &&
                      (f3 != 3'b011) && !f3[2];
    assign do_alu   = ((opcode == OP_IMM) && opimm_ok) ||
                      ((opcode == OP_REG) && op_ok);

    assign alu_b = (opcode == OP_REG) ? rs2_v : imm_i;
    assign shamt = alu_b[4:0];

    // Integer ALU shared by register and immediate forms
    always_comb begin
        alu_y = 32'h0;
        case (f3)
            3'b000: alu_y = ((opcode == OP_REG) && f7[5]) ?
                            rs1_v - alu_b : rs1_v + alu_b;
            3'b001: alu_y = rs1_v << shamt;
            3'b010: alu_y = {31'h0, $signed(rs1_v) < $signed(alu_b)};
            3'b011: alu_y = {31'h0, rs1_v < alu_b};
            3'b100: alu_y = rs1_v ^ alu_b;
            3'b101: alu_y = f7[5] ? $unsigned($signed(rs1_v) >>> shamt) :
                            rs1_v >> shamt;
            3'b110: alu_y = rs1_v | alu_b;
            default: alu_y = rs1_v & alu_b;
        endcase
    end

    // Branch condition
    always_comb begin
        br_take = 1'b0;
        case (f3)
            3'b000: br_take = (rs1_v == rs2_v);
            3'b001: br_take = (rs1_v != rs2_v);
            3'b100: br_take = $signed(rs1_v) < $signed(rs2_v);
            3'b101: br_take = $signed(rs1_v) >= $signed(rs2_v);
            3'b110: br_take = rs1_v < rs2_v;
            3'b111: br_take = rs1_v >= rs2_v;
            default: br_take = 1'b0;
        endcase
    end

    assign ea = rs1_v + (do_st ? imm_s : imm_i);

    // Byte lanes and lane-replicated store data for the access size
    always_comb begin
        mem_sel  = 4'b1111;
        mem_wdat = rs2_v;
        case (f3[1:0])
            2'b00: begin
                mem_sel  = 4'b0001 << ea[1:0];
                mem_wdat = {4{rs2_v[7:0]}};
            end
            2'b01: begin
                mem_sel  = ea[1] ? 4'b1100 : 4'b0011;
                mem_wdat = {2{rs2_v[15:0]}};
            end
            default: begin
                mem_sel  = 4'b1111;
                mem_wdat = rs2_v;
            end
        endcase
    end

    // Load lane extraction with sign or zero extension
    always_comb begin
        ld_b = wb_dbus_dat_i[7:0];
        case (ea_lo_q)
            2'd0: ld_b = wb_dbus_dat_i[7:0];
            2'd1: ld_b = wb_dbus_dat_i[15:8];
            2'd2: ld_b = wb_dbus_dat_i[23:16];
            default: ld_b = wb_dbus_dat_i[31:24];
        endcase
        ld_h = ea_lo_q[1] ? wb_dbus_dat_i[31:16] : wb_dbus_dat_i[15:0];
        case (f3)
            3'b000: ld_v = {{24{ld_b[7]}}, ld_b};
            3'b001: ld_v = {{16{ld_h[15]}}, ld_h};
            3'b100: ld_v = {24'h0, ld_b};
            3'b101: ld_v = {16'h0, ld_h};
            default: ld_v = wb_dbus_dat_i;
        endcase
    end

    // Main FSM: next state, PC, bus requests and register writeback
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        dadr_d  = dadr_q;
        ddat_d  = ddat_q;
        dsel_d  = dsel_q;
        dwe_d   = dwe_q;
        dstb_d  = dstb_q;
        ea_lo_d = ea_lo_q;
        rf_we   = 1'b0;
        rf_wa   = rd;
        rf_wd   = 32'h0;
        case (state_q)
            S_FETCH: begin
                if (wb_ibus_ack_i) begin
                    ir_d    = wb_ibus_dat_i;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_plus4;
                unique case (1'b1)
                    do_lui: begin
                        rf_we = 1'b1;
                        rf_wd = imm_u;
                    end
                    do_auipc: begin
                        rf_we = 1'b1;
                        rf_wd = pc_q + imm_u;
                    end
                    do_jal: begin
                        rf_we = 1'b1;
                        rf_wd = pc_plus4;
                        pc_d  = pc_q + imm_j;
                    end
                    do_jalr: begin
                        rf_we = 1'b1;
                        rf_wd = pc_plus4;
                        pc_d  = (rs1_v + imm_i) & 32'hFFFF_FFFE;
                    end
                    do_br: begin
                        if (br_take) begin
                            pc_d = pc_q + imm_b;
                        end
                    end
                    do_alu: begin
                        rf_we = 1'b1;
                        rf_wd = alu_y;
                    end
                    do_ld, do_st: begin
                        state_d = S_MEM;
                        dadr_d  = {ea[31:2], 2'b00};
                        ddat_d  = do_st ? mem_wdat : 32'h0;
                        dsel_d  = mem_sel;
                        dwe_d   = do_st;
                        dstb_d  = 1'b1;
                        ea_lo_d = ea[1:0];
                    end
                    default: begin
                        pc_d = pc_plus4;
                    end
                endcase
            end
            S_MEM: begin
                if (wb_dbus_ack_i) begin
                    state_d = S_FETCH;
                    dstb_d  = 1'b0;
                    dwe_d   = 1'b0;
                    rf_we   = !dwe_q;
                    rf_wd   = ld_v;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Architectural and bus state, cleared by the async reset
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0013;
            dadr_q  <= 32'h0;
            ddat_q  <= 32'h0;
            dsel_q  <= 4'h0;
            dwe_q   <= 1'b0;
            dstb_q  <= 1'b0;
            ea_lo_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            dadr_q  <= dadr_d;
            ddat_q  <= ddat_d;
            dsel_q  <= dsel_d;
            dwe_q   <= dwe_d;
            dstb_q  <= dstb_d;
            ea_lo_q <= ea_lo_d;
        end
    end

    // Register file; contents survive reset, x0 is never written
    always_ff @(posedge wb_clk_i) begin
        if (rf_we && (rf_wa != 5'd0)) begin
            rf[rf_wa] <= rf_wd;
        end
    end

    assign wb_ibus_adr_o = {pc_q[31:2], 2'b00};
    assign wb_ibus_stb_o = (state_q == S_FETCH) && wb_rst_i;
    assign wb_dbus_adr_o = dadr_q;
    assign wb_dbus_dat_o = ddat_q;
    assign wb_dbus_we_o  = dwe_q;
    assign wb_dbus_sel_o = dsel_q;
    assign wb_dbus_stb_o = dstb_q;
    assign wb_dbus_cyc_o = dstb_q;

endmodule

// File: tb/tb_atom_rv_wb_core.sv
// tb_atom_rv_wb_core: directed program on 1-wait Wishbone ROM/RAM models,
// checking bus traffic, fetch order, timing and stored register values.
module tb_atom_rv_wb_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] ibus_adr;
    logic [31:0] ibus_dat;
    logic        ibus_stb;
    logic        ibus_ack;
    logic [31:0] dbus_adr;
    logic [31:0] dbus_wdat;
    logic [31:0] dbus_rdat;
    logic        dbus_we;
    logic [3:0]  dbus_sel;
    logic        dbus_stb;
    logic        dbus_ack;
    logic        dbus_cyc;

    logic [31:0] imem [0:63];
    logic [31:0] ram  [0:1023];

    int iwait;
    int dwait;
    int cyc;
    int n_chk;
    int n_fail;

    logic [31:0] f_adr [$];
    int          f_cyc [$];
    logic [31:0] d_adr [$];
    logic [31:0] d_dat [$];
    logic [3:0]  d_sel [$];
    logic        d_we  [$];
    logic        d_cy  [$];

    atom_rv_wb_core #(.RESET_PC(32'h0)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst_n),
        .wb_ibus_adr_o (ibus_adr),
        .wb_ibus_dat_i (ibus_dat),
        .wb_ibus_stb_o (ibus_stb),
        .wb_ibus_ack_i (ibus_ack),
        .wb_dbus_adr_o (dbus_adr),
        .wb_dbus_dat_o (dbus_wdat),
        .wb_dbus_dat_i (dbus_rdat),
        .wb_dbus_we_o  (dbus_we),
        .wb_dbus_sel_o (dbus_sel),
        .wb_dbus_stb_o (dbus_stb),
        .wb_dbus_ack_i (dbus_ack),
        .wb_dbus_cyc_o (dbus_cyc)
    );

    assign ibus_dat  = imem[ibus_adr[7:2]];
    assign dbus_rdat = ram[dbus_adr[11:2]];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Instruction ROM responder: ack after iwait request cycles
    initial begin
        int cnt;
        cnt = 0;
        ibus_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ibus_stb && !ibus_ack) begin
                if (cnt >= iwait) begin
                    ibus_ack = 1'b1;
                    cnt = 0;
                    f_adr.push_back(ibus_adr);
                    f_cyc.push_back(cyc);
                end else begin
                    cnt++;
                end
            end else begin
                ibus_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Data RAM responder: byte-lane writes, logs every transfer
    initial begin
        int cnt;
        cnt = 0;
        dbus_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (dbus_stb && !dbus_ack) begin
                if (cnt >= dwait) begin
                    dbus_ack = 1'b1;
                    cnt = 0;
                    d_adr.push_back(dbus_adr);
                    d_dat.push_back(dbus_wdat);
                    d_sel.push_back(dbus_sel);
                    d_we.push_back(dbus_we);
                    d_cy.push_back(dbus_cyc);
                    if (dbus_we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (dbus_sel[b]) begin
                                ram[dbus_adr[11:2]][b*8 +: 8] =
                                    dbus_wdat[b*8 +: 8];
                            end
                        end
                    end
                end else begin
                    cnt++;
                end
            end else begin
                dbus_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    logic [31:0] exp_f [0:21];
    logic [31:0] exp_da [0:11];
    logic [3:0]  exp_ds [0:11];
    logic        exp_dw [0:11];
    logic [31:0] exp_dd [0:11];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        iwait  = 3;
        dwait  = 1;
        rst_n  = 1'b0;

        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        imem[0]  = 32'hFFF00093; // addi x1,x0,-1
        imem[1]  = 32'h4040D113; // srai x2,x1,4
        imem[2]  = 32'h001031B3; // sltu x3,x0,x1
        imem[3]  = 32'h0AB00293; // addi x5,x0,0xAB
        imem[4]  = 32'h00000463; // beq x0,x0,+8
        imem[5]  = 32'h20102E23; // sw x1,0x21C(x0) (skipped)
        imem[6]  = 32'h10100383; // lb x7,0x101(x0)
        imem[7]  = 32'h10201403; // lh x8,0x102(x0)
        imem[8]  = 32'h10304483; // lbu x9,0x103(x0)
        imem[9]  = 32'h105001A3; // sb x5,0x103(x0)
        imem[10] = 32'h20102023; // sw x1,0x200(x0)
        imem[11] = 32'h20202223; // sw x2,0x204(x0)
        imem[12] = 32'h20302423; // sw x3,0x208(x0)
        imem[13] = 32'h20702623; // sw x7,0x20C(x0)
        imem[14] = 32'h20802823; // sw x8,0x210(x0)
        imem[15] = 32'h20902A23; // sw x9,0x214(x0)
        imem[16] = 32'h00C0006F; // jal x0,+12
        imem[17] = 32'h22102023; // sw x1,0x220(x0)
        imem[18] = 32'h00C0006F; // jal x0,+12
        imem[19] = 32'hFF9FF0EF; // jal x1,-8
        imem[20] = 32'h00000013; // nop
        imem[21] = 32'h00500013; // addi x0,x0,5
        imem[22] = 32'h22002223; // sw x0,0x224(x0)
        imem[23] = 32'h0000006F; // jal x0,0
        ram[32'h40] = 32'h80FF7F01;
        ram[32'h87] = 32'hDEADBEEF;
        ram[32'h89] = 32'hDEADBEEF;

        exp_f = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h18,
                  32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30,
                  32'h34, 32'h38, 32'h3C, 32'h40, 32'h4C, 32'h44,
                  32'h48, 32'h54, 32'h58, 32'h5C};
        exp_da = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200, 32'h204,
                   32'h208, 32'h20C, 32'h210, 32'h214, 32'h220, 32'h224};
        exp_ds = '{4'b0010, 4'b1100, 4'b1000, 4'b1000, 4'hF, 4'hF,
                   4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        exp_dw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_dd = '{32'h0, 32'h0, 32'h0, 32'hABABABAB, 32'hFFFFFFFF,
                   32'hFFFFFFFF, 32'h1, 32'h7F, 32'hFFFF80FF, 32'h80,
                   32'h50, 32'h0};

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_ibus_stb", 64'(ibus_stb), 64'h0);
        chk("rst_dbus_stb", 64'(dbus_stb), 64'h0);
        chk("rst_dbus_cyc", 64'(dbus_cyc), 64'h0);
        chk("rst_dbus_we_sel", {dbus_we, dbus_sel}, 64'h0);
        chk("rst_dbus_adr_dat", {dbus_adr, dbus_wdat}, 64'h0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("first_fetch", {ibus_adr, 31'h0, ibus_stb}, {32'h0, 32'h1});

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_hold_%0d", i),
                {ibus_adr, 31'h0, ibus_stb}, {32'h0, 32'h1});
        end

        for (int i = 0; i < 20 && f_adr.size() < 1; i++) @(negedge clk);
        chk("first_ack_seen", 64'(f_adr.size() >= 1), 64'h1);
        iwait = 1;

        for (int i = 0; i < 3000 && f_adr.size() < 24; i++) begin
            @(negedge clk);
        end
        chk("fetch_count", 64'(f_adr.size() >= 24), 64'h1);

        if (f_adr.size() >= 22) begin
            for (int i = 0; i < 22; i++) begin
                chk($sformatf("fetch_%0d", i), 64'(f_adr[i]),
                    64'(exp_f[i]));
            end
            chk("alu_cycles", 64'(f_cyc[2] - f_cyc[1]), 64'd3);
            chk("load_cycles", 64'(f_cyc[6] - f_cyc[5]), 64'd5);
            chk("store_cycles", 64'(f_cyc[10] - f_cyc[9]), 64'd5);
        end

        chk("dbus_count", 64'(d_adr.size()), 64'd12);
        if (d_adr.size() >= 12) begin
            for (int i = 0; i < 12; i++) begin
                chk($sformatf("dbus_%0d_adr_sel_we_cyc", i),
                    {d_adr[i], d_sel[i], d_we[i], d_cy[i]},
                    {exp_da[i], exp_ds[i], exp_dw[i], 1'b1});
                if (exp_dw[i]) begin
                    chk($sformatf("dbus_%0d_dat", i), 64'(d_dat[i]),
                        64'(exp_dd[i]));
                end
            end
        end

        chk("ram_100", 64'(ram[32'h40]), 64'hABFF7F01);
        chk("ram_21c_untouched", 64'(ram[32'h87]), 64'hDEADBEEF);
        chk("ram_220_link", 64'(ram[32'h88]), 64'h50);
        chk("ram_224_x0", 64'(ram[32'h89]), 64'h0);

        for (int i = 0; i < 20 && !ibus_stb; i++) @(negedge clk);
        chk("pre_abort_stb", 64'(ibus_stb), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ibus_stb", 64'(ibus_stb), 64'h0);
        chk("abort_ibus_adr", 64'(ibus_adr), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
